pwm_signal_source: RTL
======================

PWM_SIGNAL_SOURCE -- requirements
Module: pwm_signal_source

Interface
REQ-001 The module SHALL take parameter CNT_W, default 16, as the width of the period and high-time counts.
REQ-002 The module SHALL have port Clk, input, 1 bit: 100 MHz system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port En, input, 1 bit: 1 = generate waveform, 0 = idle with output low.
REQ-005 The module SHALL have port Load, input, 1 bit: single-cycle request to stage PeriodIn/HighIn.
REQ-006 The module SHALL have port PeriodIn, input, CNT_W bits: period in Clk cycles.
REQ-007 The module SHALL have port HighIn, input, CNT_W bits: high time in Clk cycles.
REQ-008 The module SHALL have port SignalOut, output, 1 bit: registered waveform driven to the meter inputs (Fxin/Pxin/Dxin).
REQ-009 The module SHALL have port PeriodStart, output, 1 bit: one-cycle pulse on the first cycle of each period.
REQ-010 The module SHALL have port LoadAck, output, 1 bit: one-cycle pulse acknowledging Load.
REQ-011 The module SHALL have port Pending, output, 1 bit: staged settings not yet applied.

Function
REQ-012 The module SHALL implement states IDLE and RUN; IDLE->RUN when En=1, RUN->IDLE when En=0, taking effect at the next edge.
REQ-013 In IDLE, SignalOut, PeriodStart and the period counter Cnt SHALL be 0.
REQ-014 On IDLE->RUN, the module SHALL copy any staged settings into the active registers (P, H), clear Pending, and set Cnt=0.
REQ-015 In RUN, Cnt SHALL count 0..P-1 and wrap to 0.
REQ-016 SignalOut SHALL be 1 exactly when Cnt<H.
REQ-017 PeriodStart SHALL be 1 exactly when Cnt==0, in RUN only.
REQ-018 On entering RUN, the first period SHALL begin on the first RUN cycle: Cnt=0, PeriodStart=1, and SignalOut=1 if H>0.
REQ-019 An accepted Load SHALL capture PeriodIn/HighIn into staging, set Pending=1, and pulse LoadAck on the following cycle; Load is accepted in any state.
REQ-020 If Load is asserted while Pending=1, the new values SHALL overwrite the staging (last write wins) and LoadAck SHALL pulse again.
REQ-021 If Pending=1, staged values SHALL become active at the wrap edge (Cnt P-1 -> 0), and Pending SHALL clear on that edge; the new period begins with the new values.
REQ-022 If Load coincides with the wrap edge, the old staged values SHALL apply and the new Load SHALL be staged with Pending remaining 1.
REQ-023 Values SHALL be clamped when applied: P=max(PeriodIn,2).
REQ-024 H=0 SHALL hold SignalOut constantly low.
REQ-025 H>=P SHALL hold SignalOut constantly high, while PeriodStart still pulses every P cycles.
REQ-026 All comparisons SHALL be unsigned CNT_W-bit; Cnt SHALL never exceed P-1.
REQ-027 When En falls mid-period, the module SHALL enter IDLE at the next edge and abandon the partial period; Pending and staging SHALL be retained.

Reset
REQ-028 Rst SHALL take priority over all inputs.
REQ-029 Rst SHALL force state IDLE, Cnt=0, SignalOut=0, PeriodStart=0, LoadAck=0 and Pending=0.
REQ-030 Rst SHALL set the active registers to P=2, H=1 (50% duty, 50 MHz).
REQ-031 A Load asserted together with Rst SHALL be ignored, with no LoadAck.

Structure
REQ-032 The shared package pwm_pkg SHALL hold the state enum (IDLE, RUN), MIN_PERIOD=2, and the reset defaults RST_PERIOD=2 and RST_HIGH=1.
REQ-033 The period counter SHALL be one sub-module, pwm_period_counter, with inputs Clk, Rst, Run and P and outputs Cnt and Wrap.
REQ-034 Staging, clamping, the FSM and output registers SHALL remain in pwm_signal_source.

Verification
REQ-035 The bench SHALL cover: after Rst, Load P=10, H=3, then En=1 -> SignalOut high for 3 cycles and low for 7, repeating; PeriodStart every 10 cycles; LoadAck one cycle after Load.
REQ-036 The bench SHALL cover: while running P=10/H=3, Load P=4/H=2 at Cnt=5 -> Pending=1 until the wrap, then a 2-high/2-low pattern starting at the next PeriodStart, with no glitch in the current period.
REQ-037 The bench SHALL cover: Load with PeriodIn=0, HighIn=0 -> P=2, SignalOut constantly low; then Load PeriodIn=8, HighIn=20 -> SignalOut constantly high, PeriodStart every 8 cycles.
REQ-038 The bench SHALL cover: Load asserted in the same cycle as the wrap -> the previous staged values apply; the new values apply one full period later; Pending stays 1 across.
REQ-039 The bench SHALL cover: En dropped at Cnt=4 of P=10 -> SignalOut=0 and Cnt=0 the next cycle; En re-raised -> a fresh period starts with Cnt=0 and PeriodStart=1.
REQ-040 The bench SHALL cover: Rst asserted mid-RUN with Pending=1 -> all outputs 0 and Pending=0; after release with En=1, P=2/H=1 gives a 1-high/1-low waveform.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM signal source.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned RST_PERIOD = 2;
  localparam int unsigned RST_HIGH   = 1;

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter: counts 0..P-1 while Run is held, returns to 0 otherwise.
module pwm_period_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic [CNT_W-1:0] P,
  output logic [CNT_W-1:0] Cnt,
  output logic             Wrap
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    // >= keeps the count bounded even if P were ever smaller than the count
    Wrap  = Run && (cnt_q >= (P - CNT_W'(1)));
    cnt_d = '0;
    if (Run && !Wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Cnt = cnt_q;

endmodule

// File: rtl/pwm_signal_source.sv
// PWM generator with double-buffered period/high-time settings that take
// effect only at period boundaries or when the generator starts.
module pwm_signal_source
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Load,
  input  logic [CNT_W-1:0] PeriodIn,
  input  logic [CNT_W-1:0] HighIn,
  output logic             SignalOut,
  output logic             PeriodStart,
  output logic             LoadAck,
  output logic             Pending
);

  pwm_state_e       state_d, state_q;
  logic [CNT_W-1:0] p_d, p_q, h_d, h_q;
  logic [CNT_W-1:0] stg_p_d, stg_p_q, stg_h_d, stg_h_q;
  logic             pend_d, pend_q, ack_d, ack_q, sig_d, sig_q, ps_d, ps_q;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wrap, run, apply;

  assign state_d = En ? RUN : IDLE;
  // Counter only advances across edges where we stay in RUN; entry and exit both land on 0
  assign run     = (state_q == RUN) && (state_d == RUN);

  pwm_period_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .Clk  (Clk),
    .Rst  (Rst),
    .Run  (run),
    .P    (p_q),
    .Cnt  (cnt),
    .Wrap (wrap)
  );

  always_comb begin
    apply   = pend_q && (((state_q == IDLE) && (state_d == RUN)) || wrap);
    p_d     = p_q;
    h_d     = h_q;
    stg_p_d = stg_p_q;
    stg_h_d = stg_h_q;
    pend_d  = pend_q && !apply;
    ack_d   = Load;
    if (apply) begin
      p_d = (stg_p_q < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : stg_p_q;
      h_d = stg_h_q;
    end
    // A load on the apply edge is staged after the old staging was consumed
    if (Load) begin
      stg_p_d = PeriodIn;
      stg_h_d = HighIn;
      pend_d  = 1'b1;
    end
    // Outputs are registered, so derive them from the count the next cycle will hold
    cnt_nxt = (run && !wrap) ? (cnt + CNT_W'(1)) : '0;
    sig_d   = (state_d == RUN) && (cnt_nxt < h_d);
    ps_d    = (state_d == RUN) && (cnt_nxt == '0);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      p_q     <= CNT_W'(RST_PERIOD);
      h_q     <= CNT_W'(RST_HIGH);
      stg_p_q <= CNT_W'(RST_PERIOD);
      stg_h_q <= CNT_W'(RST_HIGH);
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      sig_q   <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      h_q     <= h_d;
      stg_p_q <= stg_p_d;
      stg_h_q <= stg_h_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      sig_q   <= sig_d;
      ps_q    <= ps_d;
    end
  end

  assign SignalOut   = sig_q;
  assign PeriodStart = ps_q;
  assign LoadAck     = ack_q;
  assign Pending     = pend_q;

endmodule
